mem_arbiter_rr: RTL
===================

Name: mem_arbiter_rr

Overview:
- Parametrised round-robin arbiter between NUM_PORTS cache-line requesters (icache, dcache, future prefetcher/L2 ports) and a single cacheline_adaptor-style memory port.
- Generalises the fixed two-port arbiter: configurable port count, line width and address width.
- Fair rotating priority; address and write data captured at grant; registered outputs on both sides.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- LINE_WIDTH, 256, cache line width in bits.
- ADDR_WIDTH, 32, address width in bits.
- IDX_W, $clog2(NUM_PORTS), width of the grant index (derived; not to be overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_PORTS  per-port line read request, held until its req_resp.
- req_write  in  NUM_PORTS  per-port line write request, held until its req_resp.
- req_address  in  NUM_PORTS*ADDR_WIDTH  port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*LINE_WIDTH  port p at bits [p*LINE_WIDTH +: LINE_WIDTH].
- req_rdata  out  LINE_WIDTH  read line, broadcast to all ports, valid only with req_resp.
- req_resp  out  NUM_PORTS  one-hot completion pulse.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write line.
- mem_rdata  in  LINE_WIDTH  memory read line.
- mem_resp  in  1  memory completion, one-cycle pulse.
- busy  out  1  high in BUSY and DONE states.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; last_grant=NUM_PORTS-1, so port 0 has top priority.
  - All outputs 0.
  - mem_read and mem_write drop immediately, even mid-transaction; any in-flight memory response after reset is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Port p is requesting if req_read[p] | req_write[p].
  - Scan from (last_grant+1) mod NUM_PORTS upward with wrap; first requesting port wins, index g.
  - On the next edge: latch g into last_grant; latch req_address[g] into mem_address; set mem_write=req_write[g] and mem_read=~req_write[g].
  - If mem_write is set, latch req_wdata[g] into mem_wdata.
  - If req_read[g] and req_write[g] are both set, write wins (illegal input; write must be served).
  - Go to BUSY. With no request, stay in IDLE with all mem_* outputs 0.
- BUSY:
  - mem_read/mem_write, mem_address and mem_wdata held constant.
  - Requester input changes are ignored; latched values govern.
  - On mem_resp: next edge clears mem_read/mem_write, sets req_resp[last_grant]=1, latches req_rdata=mem_rdata (reads only; writes leave req_rdata unchanged), goes to DONE.
- DONE:
  - Exactly one cycle. req_resp deasserts on exit; returns to IDLE.
  - Gives the requester one cycle to drop its request, so a stale request is never re-granted.
- Latency:
  - Request seen in IDLE at edge 0 → mem_* asserted after edge 0.
  - mem_resp at edge k → req_resp high from edge k to k+1.
  - Next arbitration sampled at edge k+2.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 transactions.
- Requests arriving while busy wait; no queueing beyond the held request lines.
- mem_resp outside BUSY is ignored.
- Synthesizable for NUM_PORTS not a power of two: the wrap uses modulo compare, and unused index codes never win.

Test Plan:
- Single read, NUM_PORTS=2: port1 requests read at 0x0000_1000; mem_resp after 5 cycles with line 0xA5..A5.
  → mem_read=1 with mem_address=0x1000 from the cycle after the request; req_resp=2'b10 for exactly one cycle carrying 0xA5..A5; mem_read=0 afterwards.
- Simultaneous requests, NUM_PORTS=3: all ports hold reads from reset.
  → grant order 0,1,2,0; each req_resp one-hot in the matching bit.
- Write capture: port0 writes addr 0x80 with data D1, then changes req_wdata to D2 while in BUSY.
  → mem_write=1, mem_wdata=D1 throughout; req_rdata unchanged at req_resp.
- Read/write conflict: port1 asserts both read and write.
  → mem_write=1, mem_read=0 for that transaction.
- Stale request: port0 drops its request on the req_resp cycle while port1 is requesting.
  → next grant is port1; port0 is not re-granted.
- Reset mid-BUSY: reset_n low during an outstanding read, then a late mem_resp.
  → mem_read=0 and all outputs 0 immediately; after release, state IDLE, no req_resp pulse, next grant starts at port 0.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter between NUM_PORTS cache-line requesters and one
// cacheline_adaptor-style memory port. The winning port's address and write
// line are captured at grant; both sides are driven from registers.
module mem_arbiter_rr #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IDX_W      = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    input  logic [LINE_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_resp,
    output logic                             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_address_q, mem_address_d;
    logic [LINE_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [LINE_WIDTH-1:0]  req_rdata_q, req_rdata_d;
    logic [NUM_PORTS-1:0]   req_resp_q, req_resp_d;

    logic [NUM_PORTS-1:0]   req_any;
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
    logic [LINE_WIDTH-1:0]  wdata_arr [NUM_PORTS];
    logic                   grant_found;
    logic [IDX_W-1:0]       grant_idx;

    assign req_any = req_read | req_write;

    // Split the flat per-port buses into arrays indexed by port number
    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_unpack
        assign addr_arr[gp]  = req_address[gp*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gp] = req_wdata[gp*LINE_WIDTH +: LINE_WIDTH];
    end

    // Rotating-priority search starting just after the last granted port.
    // Candidates are reduced modulo NUM_PORTS, so index codes >= NUM_PORTS
    // (non-power-of-two port counts) can never be selected.
    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = 32'(last_grant_q) + 32'd1 + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!grant_found && req_any[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Next-state and datapath capture for the IDLE/BUSY/DONE handshake
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        req_rdata_d   = req_rdata_q;
        req_resp_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    // Write takes precedence when a port raises both strobes
                    last_grant_d  = grant_idx;
                    mem_address_d = addr_arr[grant_idx];
                    mem_write_d   = req_write[grant_idx];
                    mem_read_d    = ~req_write[grant_idx];
                    if (req_write[grant_idx]) begin
                        mem_wdata_d = wdata_arr[grant_idx];
                    end
                    state_d = S_BUSY;
                end else begin
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    mem_address_d = '0;
                    mem_wdata_d   = '0;
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    mem_read_d               = 1'b0;
                    mem_write_d              = 1'b0;
                    req_resp_d[last_grant_q] = 1'b1;
                    if (mem_read_q) begin
                        req_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // One dead cycle lets the served port drop its request
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the memory strobes at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= IDX_W'(NUM_PORTS - 1);
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            req_rdata_q   <= '0;
            req_resp_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            req_rdata_q   <= req_rdata_d;
            req_resp_q    <= req_resp_d;
        end
    end

    assign req_rdata   = req_rdata_q;
    assign req_resp    = req_resp_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q == S_BUSY) || (state_q == S_DONE);

endmodule
